// File: rtl/gate_reduce_pipe.sv
// Two-stage pipelined N-lane bit-wise gate reduction (AND/NAND/OR/NOR/XOR/XNOR) with valid/ready.
// Define GATE_ACC_EN to fold multi-beat packets (delimited by in_last) into one result.
module gate_reduce_pipe #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [2:0]              in_op,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // in_op[2:1] selects the base op, in_op[0] inverts the final result
  localparam logic [1:0] BASE_AND = 2'd0;
  localparam logic [1:0] BASE_OR  = 2'd1;
  localparam logic [1:0] BASE_XOR = 2'd2;

  function automatic logic [WIDTH-1:0] combine(input logic [1:0] base,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (base)
      BASE_AND: combine = a & b;
      BASE_OR:  combine = a | b;
      BASE_XOR: combine = a ^ b;
      default:  combine = '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] reduce_lanes(input logic [1:0] base,
                                                    input logic [N_IN*WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = d[WIDTH-1:0];
    for (int k = 1; k < N_IN; k++) begin
      r = combine(base, r, d[k*WIDTH +: WIDTH]);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] finalize(input logic [2:0] op,
                                                input logic [WIDTH-1:0] r);
    if (op[2:1] == 2'b11) begin
      finalize = '0;
    end else if (op[0]) begin
      finalize = ~r;
    end else begin
      finalize = r;
    end
  endfunction

  logic                  s1_valid;
  logic [N_IN*WIDTH-1:0] s1_data;
  logic [2:0]            s1_op;
  logic                  s1_adv;
  logic                  s2_adv;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_op   <= in_op;
      end
    end
  end

`ifdef GATE_ACC_EN
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ACC  = 1'b1;

  logic             s1_last;
  logic             state;
  logic [2:0]       acc_op;
  logic [WIDTH-1:0] acc;
  logic [2:0]       cur_op;
  logic [WIDTH-1:0] beat_red;
  logic [WIDTH-1:0] merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_last <= 1'b0;
    end else if (s1_adv && in_valid) begin
      s1_last <= in_last;
    end
  end

  // Mid-packet beats use the op latched from the packet's first beat
  always_comb begin
    cur_op   = (state == ST_ACC) ? acc_op : s1_op;
    beat_red = reduce_lanes(cur_op[2:1], s1_data);
    merged   = (state == ST_ACC) ? combine(cur_op[2:1], acc, beat_red) : beat_red;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      state     <= ST_IDLE;
      acc_op    <= '0;
      acc       <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        if (state == ST_IDLE) begin
          acc_op <= s1_op;
        end
        if (s1_last) begin
          out_data <= finalize(cur_op, merged);
          state    <= ST_IDLE;
        end else begin
          acc   <= merged;
          state <= ST_ACC;
        end
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = in_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= finalize(s1_op, reduce_lanes(s1_op[2:1], s1_data));
      end
    end
  end
`endif

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Scoreboard bench for gate_reduce_pipe (N_IN=4, WIDTH=8); WIDTH=1 cases use lanes replicated across all bits.
module tb_gate_reduce_pipe;
  localparam int N_IN  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [2:0]            in_op;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;

  gate_reduce_pipe #(.N_IN(N_IN), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_op(in_op), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp_val);
    total_cnt++;
    if (act === exp_val) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_val);
  endtask

  // Presents one beat from a negedge and holds it until accepted; expectation is queued on acceptance
  task automatic applyStimulus(input logic [31:0] d, input logic [2:0] op, input logic last,
                               input bit push, input logic [7:0] exp_val, input bit lat,
                               output int acc_cyc);
    int waits;
    @(negedge clk);
    in_data  = d;
    in_op    = op;
    in_last  = last;
    in_valid = 1'b1;
    #2;
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      #2;
      waits++;
    end
    acc_cyc = -1;
    if (!in_ready) begin
      checkOutput("accept_timeout", {7'b0, in_ready}, 8'h01);
    end else begin
      acc_cyc = cyc;
      if (push) exp_q.push_back('{exp_val, cyc, lat});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_op    = 'x;
  endtask

  task automatic drain();
    int waits;
    waits = 0;
    while (exp_q.size() != 0 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    repeat (2) @(negedge clk);
    checkOutput("drain_left", 8'(exp_q.size()), 8'd0);
  endtask

  // Monitor: pops on handshake, checks the held beat while stalled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("[TB] FAIL unexpected_output: got %h, expected no beat", out_data);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          checkOutput("out_data", out_data, e.data);
          if (e.lat) checkOutput("latency", 8'(cyc - e.cyc), 8'd2);
        end else begin
          checkOutput("stall_hold", out_data, exp_q[0].data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] rep_lanes(input logic [3:0] pv);
    return {{8{pv[3]}}, {8{pv[2]}}, {8{pv[1]}}, {8{pv[0]}}};
  endfunction

  initial begin
    logic [7:0]  op_exp [8];
    logic [31:0] bp_data [6];
    logic [7:0]  bp_exp [6];
    int          ac, first_ac, last_ac;

    // F0,CC,AA,FF: AND 80, OR FF, four-lane parity F0^CC^AA^FF = 69
    op_exp  = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h69, 8'h96, 8'h00, 8'h00};
    bp_data = '{32'h08040201, 32'h00000010, 32'h00000000, 32'h01004080, 32'h000000FF, 32'h0000500A};
    bp_exp  = '{8'h0F, 8'h10, 8'h00, 8'hC1, 8'hFF, 8'h5A};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_op = '0; in_last = 1'b1;
    first_ac = 0; last_ac = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", {7'b0, out_valid}, 8'h00);
    checkOutput("reset_out_data", out_data, 8'h00);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", {7'b0, in_ready}, 8'h01);

    $display("[TB] NOR sweep");
    for (int p = 0; p < 16; p++) begin
      applyStimulus(rep_lanes(4'(p)), 3'd3, 1'b1, 1'b1, (p == 0) ? 8'hFF : 8'h00, 1'b1, ac);
      if (p == 0) first_ac = ac;
      if (p == 15) last_ac = ac;
    end
    checkOutput("nor_throughput", 8'(last_ac - first_ac), 8'd15);
    drain();

    $display("[TB] op sweep");
    for (int op = 0; op < 8; op++) begin
      applyStimulus(32'hFFAACCF0, 3'(op), 1'b1, 1'b1, op_exp[op], 1'b1, ac);
    end
    drain();

    $display("[TB] back-pressure");
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          applyStimulus(bp_data[i], 3'd2, 1'b1, 1'b1, bp_exp[i], 1'b0, ac);
          if (i == 1) checkOutput("bp_in_ready_low", {7'b0, in_ready}, 8'h00);
        end
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] reset mid-stream");
    applyStimulus(32'h08040201, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0, ac);
    applyStimulus(32'h00000010, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0, ac);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {7'b0, out_valid}, 8'h00);
    checkOutput("midrst_out_data", out_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_in_ready", {7'b0, in_ready}, 8'h01);
    applyStimulus(32'h000000F0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b1, ac);
    applyStimulus(32'h0000F000, 3'd2, 1'b1, 1'b1, 8'hF0, 1'b1, ac);
    drain();

`ifdef GATE_ACC_EN
    $display("[TB] packet accumulate");
    applyStimulus(rep_lanes(4'b0000), 3'd3, 1'b0, 1'b0, 8'h00, 1'b0, ac);
    applyStimulus(rep_lanes(4'b0000), 3'd3, 1'b0, 1'b0, 8'h00, 1'b0, ac);
    applyStimulus(rep_lanes(4'b0010), 3'd3, 1'b1, 1'b1, 8'h00, 1'b1, ac);
    applyStimulus(rep_lanes(4'b0000), 3'd3, 1'b1, 1'b1, 8'hFF, 1'b1, ac);
    // Second beat asks for AND; the latched NOR must still apply
    applyStimulus(rep_lanes(4'b0000), 3'd3, 1'b0, 1'b0, 8'h00, 1'b0, ac);
    applyStimulus(rep_lanes(4'b0000), 3'd0, 1'b1, 1'b1, 8'hFF, 1'b1, ac);
    drain();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
